// File: rtl/slot_reduce_countdown.sv
// slot_reduce_countdown: debounced slot fill, selectable bitwise reduction and timed countdown
module slot_reduce_countdown #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter int TICK = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             inc,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       state_out,
  output logic [IW-1:0]    idx_out,
  output logic             done
);
  localparam int TW = $clog2(TICK);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [1:0] {FILL = 2'b00, READY = 2'b01, COUNT = 2'b10} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [WIDTH-1:0] res_q, res_d, out_q, out_d, red;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [1:0] inc_s_q, ld_s_q;
  logic inc_e_q, ld_f_q, ld_f_d, ld_e_q, done_q, done_d;
  logic inc_p, ld_p, all_nz;
  assign inc_p = inc_s_q[1] & ~inc_e_q;
  assign ld_p = ld_f_q & ~ld_e_q;
  assign idx_nxt = (idx_q == IW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
  assign data_out = out_q;
  assign state_out = state_q;
  assign idx_out = idx_q;
  assign done = done_q;
  // filtered ld follows the synchronised level only after a full stable run
  always_comb begin
    deb_d = '0;
    ld_f_d = ld_f_q;
    if (ld_s_q[1] != ld_f_q) begin
      if (deb_q == DW'(DEB_CYCLES - 1)) ld_f_d = ld_s_q[1];
      else deb_d = deb_q + 1'b1;
    end
  end
  always_comb begin
    red = (mode == 2'b00) ? '1 : '0;
    all_nz = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      red = (mode == 2'b00) ? red & slot_q[i] : (mode == 2'b10) ? red ^ slot_q[i] : red | slot_q[i];
      all_nz = all_nz & (|slot_q[i]);
    end
  end
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    idx_d = idx_q;
    res_d = res_q;
    tmr_d = tmr_q;
    out_d = out_q;
    done_d = 1'b0;
    case (state_q)
      FILL: begin
        out_d = slot_q[idx_q];
        if (all_nz) state_d = READY;
        else if (inc_p) idx_d = idx_nxt;
        else if (ld_p) begin
          slot_d[idx_q] = data_in;
          idx_d = idx_nxt;
        end
      end
      READY: begin
        res_d = red;
        out_d = res_q;
        if (inc_p) begin
          state_d = COUNT;
          tmr_d = '0;
        end
      end
      COUNT: begin
        out_d = res_q;
        if (res_q == '0) begin
          slot_d = '{default: '0};
          idx_d = '0;
          state_d = FILL;
          done_d = 1'b1;
        end else if (ld_p) begin
          state_d = READY;
          tmr_d = '0;
        end else if (tmr_q == TW'(TICK - 1)) begin
          tmr_d = '0;
          res_d = res_q - 1'b1;
        end else tmr_d = tmr_q + 1'b1;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      slot_q <= '{default: '0};
      idx_q <= '0;
      res_q <= '0;
      tmr_q <= '0;
      out_q <= '0;
      done_q <= 1'b0;
      inc_s_q <= '0;
      inc_e_q <= 1'b0;
      ld_s_q <= '0;
      ld_f_q <= 1'b0;
      ld_e_q <= 1'b0;
      deb_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      idx_q <= idx_d;
      res_q <= res_d;
      tmr_q <= tmr_d;
      out_q <= out_d;
      done_q <= done_d;
      inc_s_q <= {inc_s_q[0], inc};
      inc_e_q <= inc_s_q[1];
      ld_s_q <= {ld_s_q[0], ld};
      ld_f_q <= ld_f_d;
      ld_e_q <= ld_f_q;
      deb_q <= deb_d;
    end
  end
endmodule

// File: tb/tb_slot_reduce_countdown.sv
// tb_slot_reduce_countdown: randomized press-level stimulus against a slot-bank reference model
module tb_slot_reduce_countdown;
  logic clk = 1'b0, rst_n = 1'b0, ld = 1'b0, inc = 1'b0;
  logic [3:0] data_in = '0, data_out;
  logic [1:0] mode = '0, state_out, idx_out;
  logic done;
  int n_tests = 0, n_fail = 0, done_cnt = 0;
  int m_slot [3];
  int m_idx, m_st, m_done;
  slot_reduce_countdown #(.WIDTH(4), .DEPTH(3), .TICK(4), .DEB_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld(ld), .inc(inc), .mode(mode),
    .data_out(data_out), .state_out(state_out), .idx_out(idx_out), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;
  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic int ref_red(int m);
    int r = (m == 0) ? 15 : 0;
    for (int i = 0; i < 3; i++) r = (m == 0) ? (r & m_slot[i]) : (m == 2) ? (r ^ m_slot[i]) : (r | m_slot[i]);
    return r;
  endfunction
  function automatic bit bank_full();
    return m_slot[0] != 0 && m_slot[1] != 0 && m_slot[2] != 0;
  endfunction
  task automatic m_clear();
    for (int i = 0; i < 3; i++) m_slot[i] = 0;
    m_idx = 0;
    m_st = 0;
  endtask
  task automatic check_view(string tag);
    @(negedge clk);
    chk({tag, "_state"}, state_out, m_st);
    chk({tag, "_idx"}, idx_out, m_idx);
    chk({tag, "_data"}, data_out, (m_st == 0) ? m_slot[m_idx] : ref_red(mode));
    chk({tag, "_dones"}, done_cnt, m_done);
  endtask
  task automatic do_reset();
    ld = 0;
    inc = 0;
    rst_n = 0;
    #2;
    chk("rst_state", state_out, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_done", done, 0);
    cyc(2);
    rst_n = 1;
    cyc(2);
    m_clear();
  endtask
  task automatic press_ld(int v, int len);
    data_in = 4'(v);
    ld = 1;
    cyc(len);
    ld = 0;
    cyc(12);
    if (m_st == 0) begin
      m_slot[m_idx] = v;
      m_idx = (m_idx + 1) % 3;
      if (bank_full()) m_st = 1;
    end
  endtask
  task automatic glitch_ld();
    data_in = 4'($urandom_range(1, 15));
    repeat (3) begin
      ld = 1;
      cyc($urandom_range(1, 2));
      ld = 0;
      cyc(1);
    end
    cyc(10);
  endtask
  task automatic press_inc(int len);
    inc = 1;
    cyc(len);
    inc = 0;
    cyc(8);
    if (m_st == 0) m_idx = (m_idx + 1) % 3;
  endtask
  task automatic enter_count();
    int t = 0;
    inc = 1;
    cyc(2);
    inc = 0;
    @(negedge clk);
    while (state_out != 2'b10 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cnt_enter", state_out, 2);
  endtask
  task automatic run_count();
    int r = ref_red(mode), m = 0;
    enter_count();
    while (state_out == 2'b10 && m < 100) begin
      if (m % 4 == 2) chk("cnt_val", data_out, r - m / 4);
      @(negedge clk);
      m++;
    end
    chk("cnt_len", m, 4 * r + 1);
    chk("done_pulse", done, 1);
    chk("end_state", state_out, 0);
    chk("end_idx", idx_out, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    m_clear();
    m_done++;
    check_view("cleared");
  endtask
  task automatic abort_count();
    enter_count();
    @(posedge clk);
    #1;
    data_in = 4'($urandom_range(1, 15));
    ld = 1;
    cyc(4);
    ld = 0;
    cyc(12);
    m_st = 1;
    check_view("abort");
  endtask
  task automatic reset_mid_count();
    enter_count();
    cyc(5);
    do_reset();
    check_view("mid_rst");
  endtask
  initial begin
    int guard, act, r;
    m_done = 0;
    m_clear();
    cyc(1);
    do_reset();
    check_view("reset");
    press_ld(6, 3);
    chk("ld1_idx", idx_out, 1);
    press_ld(3, 3);
    chk("ld2_idx", idx_out, 2);
    press_ld(9, 3);
    chk("ld3_idx", idx_out, 0);
    for (int m = 1; m <= 3; m++) begin
      mode = 2'(m % 3);
      cyc(3);
      check_view("mode");
    end
    mode = 1;
    cyc(3);
    chk("or_F", data_out, 15);
    run_count();
    press_ld(6, 4);
    press_ld(3, 4);
    press_ld(9, 4);
    mode = 0;
    cyc(3);
    check_view("and0");
    run_count();
    glitch_ld();
    check_view("glitch");
    press_ld(5, 3);
    check_view("stable3");
    press_inc(2);
    press_inc(1);
    check_view("wrap");
    data_in = 7;
    ld = 1;
    cyc(3);
    inc = 1;
    cyc(2);
    inc = 0;
    cyc(1);
    ld = 0;
    cyc(12);
    m_idx = 1;
    check_view("both_ev");
    press_inc(1);
    press_inc(1);
    check_view("slot_kept");
    do_reset();
    press_ld(9, 3);
    press_ld(1, 3);
    press_ld(8, 3);
    mode = 1;
    cyc(3);
    check_view("nine");
    abort_count();
    chk("abort_or", data_out, 9);
    mode = 2;
    cyc(3);
    check_view("abort_xor");
    mode = 1;
    cyc(3);
    reset_mid_count();
    for (int it = 0; it < 10; it++) begin
      guard = 0;
      while (m_st == 0 && guard < 40) begin
        act = $urandom_range(0, 11);
        if (act < 8) press_ld((act == 0) ? 0 : $urandom_range(1, 15), $urandom_range(3, 5));
        else if (act < 10) glitch_ld();
        else press_inc($urandom_range(1, 3));
        check_view("rnd_fill");
        guard++;
      end
      chk("rnd_ready", state_out, 1);
      mode = 2'($urandom_range(0, 3));
      cyc(3);
      check_view("rnd_ready");
      r = $urandom_range(0, 2);
      if (r == 1 && ref_red(mode) >= 3) begin
        abort_count();
        run_count();
      end else if (r == 2) reset_mid_count();
      else run_count();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
